// File: rtl/wtap_pkg.sv
// Shared types and defaults for the data-memory write tap: capture-state enum,
// queued event record and the little-endian to readable byte swap.
package wtap_pkg;

    localparam int                 WTAP_ADDR_W     = 30;
    localparam int                 WTAP_DATA_W     = 32;
    localparam int                 WTAP_DEPTH      = 4;
    localparam logic [WTAP_ADDR_W-1:0] WTAP_PORT_BASE  = 30'h0;
    localparam int                 WTAP_PORT_COUNT = 14;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cap_state_t;

    typedef struct packed {
        logic [WTAP_ADDR_W-1:0] addr;
        logic [WTAP_DATA_W-1:0] data;
    } wtap_event_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage : wtap_pkg

// File: rtl/wtap_fifo.sv
// Synchronous event FIFO with wrap-bit pointers and a registered head entry,
// so the consumer side never sees a read-port mux on the storage array.
module wtap_fifo
    import wtap_pkg::*;
#(
    parameter int  DEPTH   = WTAP_DEPTH,
    parameter type entry_t = wtap_event_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0]   PTR_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [IDX_W:0]   wr_ptr;
    logic [IDX_W:0]   rd_ptr;
    logic [IDX_W:0]   count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_idx_next;
    logic             do_push;
    logic             do_pop;
    entry_t           mem [DEPTH];
    entry_t           head_q;

    assign wr_idx      = wr_ptr[IDX_W-1:0];
    assign rd_idx      = rd_ptr[IDX_W-1:0];
    assign rd_idx_next = rd_idx + IDX_ONE;
    assign count       = wr_ptr - rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= din;
    end

    // Head tracks the oldest entry; when that entry is being written this cycle, take din directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
        end else if (do_pop) begin
            if (count == PTR_ONE) begin
                head_q <= do_push ? din : '0;
            end else begin
                head_q <= mem[rd_idx_next];
            end
        end else if (empty && do_push) begin
            head_q <= din;
        end
    end

    assign head = head_q;

endmodule : wtap_fifo

// File: rtl/dmem_write_tap.sv
// Capture stage on the D-memory write bus: one event per completed store, byte-swapped,
// queued toward the test-port checker. Optional address window: WTAP_ADDR_FILTER_EN.
module dmem_write_tap
    import wtap_pkg::*;
#(
    parameter int                ADDR_W     = WTAP_ADDR_W,
    parameter int                DATA_W     = WTAP_DATA_W,
    parameter int                DEPTH      = WTAP_DEPTH,
    parameter logic [ADDR_W-1:0] PORT_BASE  = WTAP_PORT_BASE,
    parameter int                PORT_COUNT = WTAP_PORT_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [DATA_W-1:0] ev_data,
    output logic [3:0]        ev_index,
    output logic [15:0]       ev_count,
    output logic [7:0]        drop_count,
    output logic              overflow
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } event_t;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [ADDR_W-1:0] held_addr_q;
    logic              capture;
    logic [ADDR_W-1:0] offset;
    logic              in_window;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    event_t            cand;
    event_t            head;
    logic [ADDR_W-1:0] head_offset;

    // Capture FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Capture FSM: next state. HOLD persists while write-enable stays high.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_wen && !mem_stall) state_d = HOLD;
            HOLD:    if (!mem_wen)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture FSM: outputs. A held enable at the latched address is the same store, not a new one.
    always_comb begin
        capture = 1'b0;
        case (state_q)
            IDLE:    capture = mem_wen && !mem_stall;
            HOLD:    capture = mem_wen && !mem_stall && (mem_addr != held_addr_q);
            default: capture = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         held_addr_q <= '0;
        else if (capture) held_addr_q <= mem_addr;
    end

    assign offset    = mem_addr - PORT_BASE;
    assign in_window = (mem_addr >= PORT_BASE) && (offset < ADDR_W'(PORT_COUNT));

`ifdef WTAP_ADDR_FILTER_EN
    assign accept = capture && in_window;
`else
    logic unused_in_window;
    assign unused_in_window = in_window;
    assign accept           = capture;
`endif

    assign cand.addr = mem_addr;
    assign cand.data = byte_swap32(mem_wdata);

    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign push     = accept && (!fifo_full || pop);
    assign drop     = accept && fifo_full && !pop;

    wtap_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (event_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (cand),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign ev_addr     = head.addr;
    assign ev_data     = head.data;
    assign head_offset = head.addr - PORT_BASE;
    // The head register is zero when empty; gating keeps the index at zero then for any PORT_BASE.
    assign ev_index    = ev_valid ? head_offset[3:0] : 4'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) ev_count <= ev_count + 16'd1;
            if (drop) begin
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
                overflow <= 1'b1;
            end
        end
    end

endmodule : dmem_write_tap

// File: tb/tb_dmem_write_tap.sv
// Directed bench for dmem_write_tap: reset, single, stalled, back-to-back, overflow,
// drop saturation and the address window (expectations follow WTAP_ADDR_FILTER_EN).
module tb_dmem_write_tap;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_wen;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic        ev_valid;
    logic        ev_ready;
    logic [29:0] ev_addr;
    logic [31:0] ev_data;
    logic [3:0]  ev_index;
    logic [15:0] ev_count;
    logic [7:0]  drop_count;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_write_tap dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_stall  (mem_stall),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_addr    (ev_addr),
        .ev_data    (ev_data),
        .ev_index   (ev_index),
        .ev_count   (ev_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wen, input logic [29:0] addr, input logic [31:0] data,
                          input logic stall, input logic ready);
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = data;
        mem_stall = stall;
        ev_ready  = ready;
    endtask

    task automatic do_reset();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        set_in(1'b1, 30'd5, 32'h01020304, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 30'd6, 32'h05060708, 1'b0, 1'b0);
        tick();
        n_vec++; if (ev_count !== 16'd2) begin n_err++; $display("FAIL reset_pre_count: got %0d want 2", ev_count); end
        // Asynchronous reset mid-cycle with stores still on the bus.
        #2 rst = 1'b0;
        #1;
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        n_vec++; if (ev_addr !== 30'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", ev_addr); end
        n_vec++; if (ev_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", ev_data); end
        n_vec++; if (ev_index !== 4'd0) begin n_err++; $display("FAIL reset_index: got %0d want 0", ev_index); end
        n_vec++; if (ev_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", ev_count); end
        n_vec++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tick();
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_held_valid: got %b want 0", ev_valid); end
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        set_in(1'b1, 30'd7, 32'h0A0B0C0D, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (ev_count !== 16'd1) begin n_err++; $display("FAIL reset_after_count: got %0d want 1", ev_count); end
        n_vec++; if (ev_addr !== 30'd7) begin n_err++; $display("FAIL reset_after_addr: got %0d want 7", ev_addr); end
    endtask

    task automatic test_single();
        do_reset();
        set_in(1'b1, 30'd0, 32'hFEFFFFFF, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", ev_valid); end
        n_vec++; if (ev_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL single_data: got %h want fffffffe", ev_data); end
        n_vec++; if (ev_index !== 4'd0) begin n_err++; $display("FAIL single_index: got %0d want 0", ev_index); end
        n_vec++; if (ev_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", ev_count); end
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b1);
        tick();
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", ev_valid); end
    endtask

    task automatic test_stalled();
        do_reset();
        set_in(1'b1, 30'd3, 32'hAABBCCDD, 1'b1, 1'b0);
        tick();
        tick();
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL stall_early_valid: got %b want 0", ev_valid); end
        set_in(1'b1, 30'd3, 32'hAABBCCDD, 1'b0, 1'b0);
        tick();
        n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", ev_valid); end
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (ev_count !== 16'd1) begin n_err++; $display("FAIL stall_count: got %0d want 1", ev_count); end
        n_vec++; if (ev_data !== 32'hDDCCBBAA) begin n_err++; $display("FAIL stall_data: got %h want ddccbbaa", ev_data); end
        n_vec++; if (ev_index !== 4'd3) begin n_err++; $display("FAIL stall_index: got %0d want 3", ev_index); end
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b1);
        tick();
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL stall_single_event: got %b want 0", ev_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(1'b1, 30'd1, 32'h11223344, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 30'd2, 32'hA0B0C0D0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (ev_count !== 16'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", ev_count); end
        n_vec++; if (ev_index !== 4'd1) begin n_err++; $display("FAIL b2b_first_index: got %0d want 1", ev_index); end
        n_vec++; if (ev_data !== 32'h44332211) begin n_err++; $display("FAIL b2b_first_data: got %h want 44332211", ev_data); end
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b1);
        tick();
        n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b want 1", ev_valid); end
        n_vec++; if (ev_index !== 4'd2) begin n_err++; $display("FAIL b2b_second_index: got %0d want 2", ev_index); end
        n_vec++; if (ev_data !== 32'hD0C0B0A0) begin n_err++; $display("FAIL b2b_second_data: got %h want d0c0b0a0", ev_data); end
        tick();
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", ev_valid); end
    endtask

    task automatic test_overflow();
        logic [29:0] exp_addr [4];
        logic [31:0] exp_data [4];
        exp_addr = '{30'd5, 30'd6, 30'd7, 30'd10};
        exp_data = '{32'h02000000, 32'h03000000, 32'h04000000, 32'h0A000000};
        do_reset();
        // Six distinct stores into a four-entry FIFO: addresses 4..9, data 1..6.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 30'(4 + i), 32'(i + 1), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (ev_count !== 16'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", ev_count); end
        n_vec++; if (drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_vec++; if (ev_addr !== 30'd4) begin n_err++; $display("FAIL ovf_head_stable: got %0d want 4", ev_addr); end
        n_vec++; if (ev_data !== 32'h01000000) begin n_err++; $display("FAIL ovf_head_data: got %h want 01000000", ev_data); end
        // Push while full with a simultaneous pop must not drop.
        set_in(1'b1, 30'd10, 32'h0000000A, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b1);
        n_vec++; if (ev_count !== 16'd5) begin n_err++; $display("FAIL ovf_concurrent_count: got %0d want 5", ev_count); end
        n_vec++; if (drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_concurrent_drop: got %0d want 2", drop_count); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL ovf_drain_valid[%0d]: got %b want 1", i, ev_valid); end
            n_vec++; if (ev_addr !== exp_addr[i]) begin n_err++; $display("FAIL ovf_drain_addr[%0d]: got %0d want %0d", i, ev_addr, exp_addr[i]); end
            n_vec++; if (ev_data !== exp_data[i]) begin n_err++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, ev_data, exp_data[i]); end
            tick();
        end
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", ev_valid); end
    endtask

    task automatic test_drop_saturate();
        do_reset();
        // 262 back-to-back stores alternating addresses 0/1: 4 queued, 258 dropped.
        for (int i = 0; i < 262; i++) begin
            set_in(1'b1, 30'(i % 2), 32'(i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL sat_drop: got %0d want 255", drop_count); end
        n_vec++; if (ev_count !== 16'd4) begin n_err++; $display("FAIL sat_count: got %0d want 4", ev_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", overflow); end
    endtask

    task automatic test_filter();
        do_reset();
        set_in(1'b1, 30'h20, 32'h12345678, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        tick();
`ifdef WTAP_ADDR_FILTER_EN
        n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL filter_valid: got %b want 0", ev_valid); end
        n_vec++; if (ev_count !== 16'd0) begin n_err++; $display("FAIL filter_count: got %0d want 0", ev_count); end
        set_in(1'b1, 30'd2, 32'h00000055, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        n_vec++; if (ev_index !== 4'd2) begin n_err++; $display("FAIL filter_inwin_index: got %0d want 2", ev_index); end
        n_vec++; if (ev_count !== 16'd1) begin n_err++; $display("FAIL filter_inwin_count: got %0d want 1", ev_count); end
`else
        n_vec++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL filter_valid: got %b want 1", ev_valid); end
        n_vec++; if (ev_index !== 4'd0) begin n_err++; $display("FAIL filter_index: got %0d want 0", ev_index); end
        n_vec++; if (ev_addr !== 30'h20) begin n_err++; $display("FAIL filter_addr: got %h want 20", ev_addr); end
        n_vec++; if (ev_data !== 32'h78563412) begin n_err++; $display("FAIL filter_data: got %h want 78563412", ev_data); end
`endif
    endtask

    initial begin
        set_in(1'b0, 30'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_stalled();
        test_back_to_back();
        test_overflow();
        test_drop_saturate();
        test_filter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule : tb_dmem_write_tap
